seq_ctrl: RTL
=============

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15, memory-wait cycles allowed before fault; legal range 1..255.
REQ-002 clock  in  1  system clock, all state updates on rising edge.
REQ-003 n_rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  leave IDLE and begin fetching.
REQ-005 mem_ready  in  1  memory completes current request this cycle.
REQ-006 op_halt, op_branch, op_load, op_store, op_alu  in  1 each  instruction class from the decoder, valid in DECODE.
REQ-007 is_br  in  1  branch-taken result from the flag register decoder.
REQ-008 mem_req  out  1  memory access request.
REQ-009 mem_we  out  1  memory write (store) qualifier for mem_req.
REQ-010 ir_we  out  1  instruction register load.
REQ-011 pc_we  out  1  PC load.
REQ-012 pc_sel  out  1  PC source: 0 = PC+1, 1 = branch target.
REQ-013 bre  out  1  branch evaluate enable to the flag register decoder.
REQ-014 flag_we  out  1  flag register update enable.
REQ-015 rf_we  out  1  register file write.
REQ-016 state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
REQ-017 icount  out  16  retired-instruction count.
REQ-018 fault  out  1  high while in FAULT.

Function
REQ-019 All strobes (mem_req, mem_we, ir_we, pc_we, pc_sel, bre, flag_we, rf_we) SHALL be Moore/Mealy decodes of state and latched class; all are 0 in IDLE, HALT and FAULT.
REQ-020 IDLE: -> FETCH on start=1; otherwise hold.
REQ-021 FETCH: mem_req=1, mem_we=0; on mem_ready=1 the same cycle ir_we=1, pc_we=1, pc_sel=0, next state DECODE; otherwise hold.
REQ-022 DECODE: one cycle; class inputs SHALL be latched with priority halt > branch > load > store > alu; none set latches NOP; latched halt -> HALT, else -> EXEC.
REQ-023 EXEC branch: bre=1, pc_sel=1, pc_we=is_br, flag_we=0, next FETCH.
REQ-024 EXEC alu: flag_we=1, next WB; EXEC load/store: next MEM; EXEC NOP: no strobes, next FETCH.
REQ-025 MEM: mem_req=1, mem_we=1 only for store; on mem_ready load -> WB, store -> FETCH; otherwise hold.
REQ-026 WB: rf_we=1 for exactly one cycle, next FETCH.
REQ-027 HALT and FAULT SHALL be exited only by reset; start is ignored there.
REQ-028 Wait counter (8 bits): cleared on entry to FETCH or MEM and on any cycle with mem_ready=1; increments each FETCH/MEM cycle with mem_ready=0.
REQ-029 When wait counter equals WAIT_MAX and mem_ready=0 in FETCH/MEM, next state SHALL be FAULT; mem_ready=1 in that same cycle wins (normal completion).
REQ-030 icount SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB; wraps 0xFFFF -> 0x0000; halt instruction does not count.
REQ-031 Illegal state encodings SHALL transition to FAULT.

Reset
REQ-032 On n_rst=0, asynchronously: state=IDLE, latched class=NOP, wait counter=0, icount=0, all outputs 0.
REQ-033 Reset asserted mid-instruction (any state) SHALL abort it with no further strobes; first post-reset cycle is IDLE.

Verification
REQ-034 start=1, mem_ready=1 always, op_alu -> states 1,2,3,5,1; flag_we=1 in EXEC, rf_we=1 in WB; icount=1 after WB.
REQ-035 op_branch with is_br=1 -> EXEC: bre=1, pc_we=1, pc_sel=1; with is_br=0 -> bre=1, pc_we=0; both return to FETCH, icount +1.
REQ-036 op_load with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_req=1, mem_we=0, then WB; op_store -> mem_we=1, WB skipped.
REQ-037 WAIT_MAX=15, mem_ready=0 in FETCH -> FAULT after 16 FETCH cycles, fault=1, start ignored; mem_ready=1 on the 16th cycle -> DECODE instead.
REQ-038 op_halt and op_branch both set -> HALT, no bre; icount preloaded to 0xFFFF then one alu instruction -> 0x0000.
REQ-039 n_rst pulsed low during MEM -> state=0, mem_req=0 immediately, icount=0.

Source files
------------

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: control/handshake bundle between the sequencer and its datapath, memory and decoder.
interface seq_ctrl_if;
  logic        start_i;
  logic        mem_ready_i;
  logic        op_halt_i;
  logic        op_branch_i;
  logic        op_load_i;
  logic        op_store_i;
  logic        op_alu_i;
  logic        is_br_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        ir_we_o;
  logic        pc_we_o;
  logic        pc_sel_o;
  logic        bre_o;
  logic        flag_we_o;
  logic        rf_we_o;
  logic [2:0]  state_o;
  logic [15:0] icount_o;
  logic        fault_o;
  modport master (
    input  start_i, mem_ready_i, op_halt_i, op_branch_i, op_load_i, op_store_i, op_alu_i, is_br_i,
    output mem_req_o, mem_we_o, ir_we_o, pc_we_o, pc_sel_o, bre_o, flag_we_o, rf_we_o,
    output state_o, icount_o, fault_o
  );
  modport slave (
    output start_i, mem_ready_i, op_halt_i, op_branch_i, op_load_i, op_store_i, op_alu_i, is_br_i,
    input  mem_req_o, mem_we_o, ir_we_o, pc_we_o, pc_sel_o, bre_o, flag_we_o, rf_we_o,
    input  state_o, icount_o, fault_o
  );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: multicycle instruction sequencer with memory-wait watchdog and retired-instruction counter.
module seq_ctrl #(
  parameter int unsigned WAIT_MAX   = 15,
  parameter logic [15:0] ICOUNT_RST = 16'h0000
) (
  input logic        clock,
  input logic        n_rst,
  seq_ctrl_if.master bus_io
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;
  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_HALT = 3'd1;
  localparam logic [2:0] C_BR   = 3'd2;
  localparam logic [2:0] C_LD   = 3'd3;
  localparam logic [2:0] C_ST   = 3'd4;
  localparam logic [2:0] C_ALU  = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [2:0]  cls_q, cls_d, dec_cls;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] icount_q, icount_d;
  logic        mem_phase, timeout;
  logic        mem_req, mem_we, ir_we, pc_we, pc_sel, bre, flag_we, rf_we;
  assign dec_cls = bus_io.op_halt_i   ? C_HALT :
                   bus_io.op_branch_i ? C_BR   :
                   bus_io.op_load_i   ? C_LD   :
                   bus_io.op_store_i  ? C_ST   :
                   bus_io.op_alu_i    ? C_ALU  : C_NOP;
  assign mem_phase = state_q == S_FETCH || state_q == S_MEM;
  // A ready memory in the last allowed wait cycle still completes normally.
  assign timeout = wait_q == 8'(WAIT_MAX) && !bus_io.mem_ready_i;
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    bre     = 1'b0;
    flag_we = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      S_IDLE: state_d = bus_io.start_i ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = bus_io.mem_ready_i;
        pc_we   = bus_io.mem_ready_i;
        state_d = bus_io.mem_ready_i ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = dec_cls == C_HALT ? S_HALT : S_EXEC;
      end
      S_EXEC: case (cls_q)
        C_BR: begin
          bre     = 1'b1;
          pc_sel  = 1'b1;
          pc_we   = bus_io.is_br_i;
          state_d = S_FETCH;
        end
        C_ALU: begin
          flag_we = 1'b1;
          state_d = S_WB;
        end
        C_LD, C_ST: state_d = S_MEM;
        C_NOP:      state_d = S_FETCH;
        default:    state_d = S_FAULT;
      endcase
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls_q == C_ST;
        state_d = bus_io.mem_ready_i ? (cls_q == C_LD ? S_WB : S_FETCH) : timeout ? S_FAULT : S_MEM;
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end
  // Counter restarts on every state change, so entering FETCH/MEM always begins at zero.
  assign wait_d = (mem_phase && !bus_io.mem_ready_i && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
  assign icount_d = (state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
                  ? icount_q + 16'd1 : icount_q;
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cls_q    <= C_NOP;
      wait_q   <= 8'd0;
      icount_q <= ICOUNT_RST;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      wait_q   <= wait_d;
      icount_q <= icount_d;
    end
  end
  assign bus_io.mem_req_o = mem_req;
  assign bus_io.mem_we_o  = mem_we;
  assign bus_io.ir_we_o   = ir_we;
  assign bus_io.pc_we_o   = pc_we;
  assign bus_io.pc_sel_o  = pc_sel;
  assign bus_io.bre_o     = bre;
  assign bus_io.flag_we_o = flag_we;
  assign bus_io.rf_we_o   = rf_we;
  assign bus_io.state_o   = state_q;
  assign bus_io.icount_o  = icount_q;
  assign bus_io.fault_o   = state_q == S_FAULT;
endmodule
